// File: rtl/clk_div_ratio_ctrl_pkg.sv
// rtl/clk_div_ratio_ctrl_pkg.sv - shared state encodings and constants for the divider ratio controller
package clk_div_ratio_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_LOW = 2'd1;
    localparam logic [1:0] ST_PARK     = 2'd2;
    localparam logic [1:0] ST_APPLY    = 2'd3;

    // Ratios at or below this value leave the divider off (bypass)
    localparam int DIV_OFF_MAX = 1;

endpackage

// File: rtl/div_fall_det.sv
// rtl/div_fall_det.sv - registers the divided clock and flags its falling edge
module div_fall_det (
    input  logic i_ref_clk,
    input  logic i_rst_n,
    input  logic i_div_clk,
    output logic o_fall
);

    logic div_clk_q;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_clk_q <= 1'b0;
        end else begin
            div_clk_q <= i_div_clk;
        end
    end

    assign o_fall = div_clk_q & ~i_div_clk;

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// rtl/clk_div_ratio_ctrl.sv - glitch-free owner of the integer divider ratio input
module clk_div_ratio_ctrl
    import clk_div_ratio_ctrl_pkg::*;
#(
    parameter int DIV_RATIO_WIDTH = 8,
    parameter int RST_RATIO       = 1,
    parameter int MAX_RATIO       = 2**DIV_RATIO_WIDTH - 1,
    parameter int PARK_CYC        = 2,
    parameter int TIMEOUT_CYC     = 2**DIV_RATIO_WIDTH
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cfg_valid,
    input  logic [DIV_RATIO_WIDTH-1:0] i_cfg_ratio,
    output logic                       o_cfg_ready,
    input  logic                       i_div_clk,
    output logic [DIV_RATIO_WIDTH-1:0] o_div_ratio,
    output logic                       o_bypass,
    output logic                       o_busy,
    output logic                       o_cfg_done,
    output logic                       o_cfg_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int PK_W = $clog2(PARK_CYC + 1);
    localparam int DRW1 = DIV_RATIO_WIDTH + 1;

    localparam logic [DIV_RATIO_WIDTH-1:0] RST_R   = DIV_RATIO_WIDTH'(RST_RATIO);
    localparam logic [DIV_RATIO_WIDTH-1:0] OFF_MAX = DIV_RATIO_WIDTH'(DIV_OFF_MAX);
    localparam logic [DRW1-1:0]            MAX_R   = DRW1'(MAX_RATIO);
    localparam logic                       RST_BYP = (RST_RATIO <= DIV_OFF_MAX);
    localparam logic [TO_W-1:0]            TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [PK_W-1:0]            PK_LAST = PK_W'(PARK_CYC - 1);

    logic [1:0]                 state;
    logic [DIV_RATIO_WIDTH-1:0] pend;
    logic [TO_W-1:0]            to_cnt;
    logic [PK_W-1:0]            park_cnt;
    logic                       fall;
    logic                       xfer;
    logic                       req_too_big;

    div_fall_det u_fall_det (
        .i_ref_clk (i_ref_clk),
        .i_rst_n   (i_rst_n),
        .i_div_clk (i_div_clk),
        .o_fall    (fall)
    );

    assign o_cfg_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);
    assign xfer        = i_cfg_valid & o_cfg_ready;
    assign req_too_big = ({1'b0, i_cfg_ratio} > MAX_R);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            pend        <= '0;
            o_div_ratio <= RST_R;
            o_bypass    <= RST_BYP;
            o_cfg_done  <= 1'b0;
            o_cfg_err   <= 1'b0;
        end else begin
            o_cfg_done <= 1'b0;
            o_cfg_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        pend <= i_cfg_ratio;
                        if (req_too_big) begin
                            o_cfg_err <= 1'b1;
                        end else if (i_cfg_ratio == o_div_ratio) begin
                            o_cfg_done <= 1'b1;
                        end else if (o_div_ratio <= OFF_MAX) begin
                            // Divider already off with its output low: park immediately
                            state       <= ST_PARK;
                            o_div_ratio <= '0;
                            o_bypass    <= 1'b1;
                        end else begin
                            state <= ST_WAIT_LOW;
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    if (fall || (to_cnt == TO_LAST)) begin
                        state       <= ST_PARK;
                        o_div_ratio <= '0;
                        o_bypass    <= 1'b1;
                    end
                end
                ST_PARK: begin
                    if (park_cnt == PK_LAST) begin
                        state       <= ST_APPLY;
                        o_div_ratio <= pend;
                        o_bypass    <= (pend <= OFF_MAX);
                        o_cfg_done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Timeout saturates rather than wrapping; only IDLE can enter WAIT_LOW, so clearing there suffices
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt   <= '0;
            park_cnt <= '0;
        end else begin
            if (state == ST_IDLE) begin
                to_cnt <= '0;
            end else if ((state == ST_WAIT_LOW) && (to_cnt != TO_LAST)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (state != ST_PARK) begin
                park_cnt <= '0;
            end else begin
                park_cnt <= park_cnt + PK_W'(1);
            end
        end
    end

endmodule
